// File: rtl/alu_pkg.sv
// ALU BIST shared definitions: opcodes, FSM states, LFSR seed and step.
// Imported by alu_ref_model and alu_bist.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTE = 3'd6;
  localparam logic [2:0] OP_EQ   = 3'd7;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } bist_state_t;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] l
  );
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Golden ALU model (combinational, unsigned compares).
// In: op1, op2, Aluop. Out: exp_result, exp_equal, exp_lessThan.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  input  logic [2:0] Aluop,
  output logic [7:0] exp_result,
  output logic       exp_equal,
  output logic       exp_lessThan
);

  always_comb begin
    exp_result   = '0;
    exp_equal    = (op1 == op2);
    exp_lessThan = (op1 < op2);
    unique case (Aluop)
      OP_AND:  exp_result = op1 & op2;
      OP_OR:   exp_result = op1 | op2;
      OP_XOR:  exp_result = op1 ^ op2;
      OP_ADD:  exp_result = op1 + op2;
      OP_SUB:  exp_result = op1 - op2;
      OP_SLT:  exp_result = {7'b0, op1 < op2};
      OP_SLTE: exp_result = {7'b0, op1 <= op2};
      OP_EQ:   exp_result = {7'b0, op1 == op2};
      default: exp_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// ALU BIST: LFSR operand pairs, all 8 opcodes each, checked vs golden model.
// Ports: clk/reset, start/num_vectors/seed, ALU drive+response, status/fail capture.
module alu_bist
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  num_vectors,
  input  logic [15:0] seed,
  output logic [7:0]  op1,
  output logic [7:0]  op2,
  output logic [2:0]  Aluop,
  input  logic [7:0]  result,
  input  logic        equal,
  input  logic        lessThan,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [7:0]  fail_op1,
  output logic [7:0]  fail_op2,
  output logic [2:0]  fail_aluop
);

  bist_state_t state;
  logic [15:0] lfsr;
  logic [8:0]  vec_left;

  logic [7:0]  exp_result;
  logic        exp_equal;
  logic        exp_lt;
  logic        mismatch;
  logic        last_check;
  logic [7:0]  err_next;
  logic [15:0] seed_eff;
  logic [15:0] lfsr_nx;

  alu_ref_model u_ref (
    .op1          (op1),
    .op2          (op2),
    .Aluop        (Aluop),
    .exp_result   (exp_result),
    .exp_equal    (exp_equal),
    .exp_lessThan (exp_lt)
  );

  assign mismatch = (result != exp_result) ||
                    (equal != exp_equal) ||
                    (lessThan != exp_lt);
  assign last_check = (Aluop == OP_EQ) &&
                      (vec_left == 9'd1);
  assign err_next = !mismatch ? err_count :
                    (err_count == 8'hFF) ? err_count :
                    err_count + 8'd1;
  assign seed_eff = (seed == 16'd0) ? DEFAULT_SEED : seed;
  assign lfsr_nx  = lfsr_step(lfsr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      lfsr       <= DEFAULT_SEED;
      vec_left   <= '0;
      op1        <= '0;
      op2        <= '0;
      Aluop      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_op1   <= '0;
      fail_op2   <= '0;
      fail_aluop <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            lfsr       <= seed_eff;
            op1        <= seed_eff[15:8];
            op2        <= seed_eff[7:0];
            Aluop      <= OP_AND;
            vec_left   <= (num_vectors == 8'd0) ? 9'd256
                          : {1'b0, num_vectors};
            err_count  <= '0;
            fail_op1   <= '0;
            fail_op2   <= '0;
            fail_aluop <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_DRIVE;
          end
        end
        S_DRIVE: state <= S_CHECK;
        S_CHECK: begin
          err_count <= err_next;
          // err_count only leaves 0 on the first mismatch
          if (mismatch && err_count == 8'd0) begin
            fail_op1   <= op1;
            fail_op2   <= op2;
            fail_aluop <= Aluop;
          end
          if (last_check) begin
            // operands stay on the last pair while idle
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
          end else begin
            state <= S_DRIVE;
            Aluop <= Aluop + 3'd1;
            if (Aluop == OP_EQ) begin
              lfsr     <= lfsr_nx;
              op1      <= lfsr_nx[15:8];
              op2      <= lfsr_nx[7:0];
              vec_left <= vec_left - 9'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
